// File: rtl/adc_lane_align.sv
// adc_lane_align: one shared trainer for NCH ADC lanes. Each lane's delay line is swept for the
// widest stable-data eye, parked at the eye centre, then bitslipped until the training word appears.
module adc_lane_align #(
  parameter int NCH      = 8,
  parameter int WIDTH    = 12,
  parameter int TAPS     = 32,
  parameter int SETTLE   = 16,
  parameter int NCHECK   = 64,
  parameter int MIN_EYE  = 4,
  parameter int SLIP_MAX = 6,
  localparam int TW      = $clog2(TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        pattern,
  input  logic [NCH*WIDTH-1:0]    des_data,
  output logic [NCH-1:0]          dly_rst,
  output logic [NCH-1:0]          dly_ce,
  output logic                    dly_inc,
  output logic [NCH-1:0]          bitslip,
  output logic                    busy,
  output logic                    done,
  output logic [NCH-1:0]          ch_ok,
  output logic [NCH-1:0]          ch_fail,
  output logic [NCH*TW-1:0]       tap_out,
  output logic [NCH*(TW+1)-1:0]   eye_len,
  output logic [3:0]              state_dbg
);

  localparam int LW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CMAX = (SETTLE > NCHECK) ? SETTLE : NCHECK;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int SW   = $clog2(SLIP_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SEL   = 4'd1,
    S_WAIT  = 4'd2,
    S_CHECK = 4'd3,
    S_STEP  = 4'd4,
    S_EVAL  = 4'd5,
    S_CRST  = 4'd6,
    S_CINC  = 4'd7,
    S_SWAIT = 4'd8,
    S_SCHK  = 4'd9,
    S_SLIP  = 4'd10,
    S_NEXT  = 4'd11,
    S_FIN   = 4'd12
  } state_t;

  state_t            state, state_n;
  logic [LW-1:0]     lane;
  logic [TW-1:0]     tap, center, cinc_cnt, res_tap, best_start, run_start, ext_start;
  logic [TW:0]       run_len, best_len, ext_len;
  logic              run_open, mismatch, cinc_ph, res_ok, res_fail;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     slips;
  logic [WIDTH-1:0]  ref_word, lane_word;
  logic [NCH-1:0]    lane_oh;

  logic last_tap, settle_done, check_done, cinc_done, last_lane, pat_match, eye_ok;
  logic good, run_close;
  logic [NCH-1:0] dly_rst_d, dly_ce_d, bitslip_d;
  logic busy_d, done_d;

  assign state_dbg = state;

  always_comb begin
    lane_word   = des_data[lane*WIDTH +: WIDTH];
    lane_oh     = '0;
    lane_oh[lane] = 1'b1;
    last_tap    = (tap == TW'(TAPS - 1));
    settle_done = (cnt == CW'(SETTLE - 1));
    check_done  = (cnt == CW'(NCHECK));
    cinc_done   = (cinc_cnt == center);
    last_lane   = (lane == LW'(NCH - 1));
    pat_match   = (lane_word == pattern);
    eye_ok      = (best_len >= (TW+1)'(MIN_EYE));
  end

  // Run tracker: a good tap extends (or opens) the run; a bad tap or the last tap closes it.
  always_comb begin
    good      = !mismatch;
    ext_len   = good ? (run_open ? run_len + 1'b1 : (TW+1)'(1)) : run_len;
    ext_start = (good && !run_open) ? tap : run_start;
    run_close = (run_open && !good) || (good && last_tap);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_SEL;
      S_SEL:   state_n = S_WAIT;
      S_WAIT:  if (settle_done) state_n = S_CHECK;
      S_CHECK: if (check_done) state_n = S_STEP;
      S_STEP:  state_n = last_tap ? S_EVAL : S_WAIT;
      S_EVAL:  state_n = eye_ok ? S_CRST : S_NEXT;
      S_CRST:  state_n = S_CINC;
      S_CINC:  if (cinc_done) state_n = S_SWAIT;
      S_SWAIT: if (settle_done) state_n = S_SCHK;
      S_SCHK: begin
        if (pat_match || (slips >= SW'(SLIP_MAX))) state_n = S_NEXT;
        else                                       state_n = S_SLIP;
      end
      S_SLIP:  state_n = S_SWAIT;
      S_NEXT:  state_n = last_lane ? S_FIN : S_SEL;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of the registered strobes; only the active lane's bit is ever set.
  always_comb begin
    dly_rst_d = '0;
    dly_ce_d  = '0;
    bitslip_d = '0;
    done_d    = (state == S_FIN);
    busy_d    = (state_n != S_IDLE);
    case (state)
      S_SEL, S_CRST: dly_rst_d = lane_oh;
      S_STEP:        if (!last_tap) dly_ce_d = lane_oh;
      S_CINC:        if (!cinc_done && !cinc_ph) dly_ce_d = lane_oh;
      S_SLIP:        bitslip_d = lane_oh;
      default:       ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_rst    <= '0;
      dly_ce     <= '0;
      dly_inc    <= 1'b1;
      bitslip    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ch_ok      <= '0;
      ch_fail    <= '0;
      tap_out    <= '0;
      eye_len    <= '0;
      lane       <= '0;
      tap        <= '0;
      center     <= '0;
      cinc_cnt   <= '0;
      cinc_ph    <= 1'b0;
      res_tap    <= '0;
      res_ok     <= 1'b0;
      res_fail   <= 1'b0;
      best_start <= '0;
      best_len   <= '0;
      run_start  <= '0;
      run_len    <= '0;
      run_open   <= 1'b0;
      mismatch   <= 1'b0;
      cnt        <= '0;
      slips      <= '0;
      ref_word   <= '0;
    end else begin
      dly_rst <= dly_rst_d;
      dly_ce  <= dly_ce_d;
      dly_inc <= 1'b1;
      bitslip <= bitslip_d;
      busy    <= busy_d;
      done    <= done_d;
      case (state)
        S_IDLE: begin
          if (start) begin
            ch_ok   <= '0;
            ch_fail <= '0;
            tap_out <= '0;
            eye_len <= '0;
            lane    <= '0;
          end
        end
        S_SEL: begin
          tap        <= '0;
          cnt        <= '0;
          run_open   <= 1'b0;
          run_len    <= '0;
          run_start  <= '0;
          best_len   <= '0;
          best_start <= '0;
          res_ok     <= 1'b0;
          res_fail   <= 1'b0;
          res_tap    <= '0;
        end
        S_WAIT, S_SWAIT: cnt <= settle_done ? '0 : cnt + 1'b1;
        S_CHECK: begin
          cnt <= cnt + 1'b1;
          // First cycle captures the reference; the next NCHECK samples must all equal it.
          if (cnt == '0) begin
            ref_word <= lane_word;
            mismatch <= 1'b0;
          end else if (lane_word != ref_word) begin
            mismatch <= 1'b1;
          end
        end
        S_STEP: begin
          cnt <= '0;
          if (!last_tap) tap <= tap + 1'b1;
          if (run_close) begin
            run_open <= 1'b0;
            // Strictly longer only, so the earliest of equal-length eyes is kept.
            if (ext_len > best_len) begin
              best_len   <= ext_len;
              best_start <= ext_start;
            end
          end else if (good) begin
            run_open  <= 1'b1;
            run_len   <= ext_len;
            run_start <= ext_start;
          end
        end
        S_EVAL: begin
          if (eye_ok) begin
            center  <= TW'(best_start + ((best_len - 1'b1) >> 1));
            res_tap <= TW'(best_start + ((best_len - 1'b1) >> 1));
          end else begin
            res_fail <= 1'b1;
            res_tap  <= '0;
          end
        end
        S_CRST: begin
          cinc_cnt <= '0;
          cinc_ph  <= 1'b0;
        end
        S_CINC: begin
          if (cinc_done) begin
            cnt   <= '0;
            slips <= '0;
          end else begin
            cinc_ph <= ~cinc_ph;
            if (!cinc_ph) cinc_cnt <= cinc_cnt + 1'b1;
          end
        end
        S_SCHK: begin
          if (pat_match)                      res_ok   <= 1'b1;
          else if (slips >= SW'(SLIP_MAX))    res_fail <= 1'b1;
        end
        S_SLIP: begin
          slips <= slips + 1'b1;
          cnt   <= '0;
        end
        S_NEXT: begin
          ch_ok[lane]                     <= res_ok;
          ch_fail[lane]                   <= res_fail;
          tap_out[lane*TW +: TW]          <= res_tap;
          eye_len[lane*(TW+1) +: (TW+1)]  <= best_len;
          if (!last_lane) lane <= lane + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_lane_align.sv
// Directed bench for adc_lane_align: each lane gets its own eye/rotation scenario from a
// behavioural IODELAY/ISERDES model, and results are compared with hand-derived values.
module tb_adc_lane_align;

  localparam int NCH    = 8;
  localparam int WIDTH  = 12;
  localparam int TAPS   = 32;
  localparam int TW     = 5;
  localparam int BOUND  = 30000;

  // Handshake: start is a single-cycle request sampled only while the DUT is idle;
  // done is a single-cycle strobe that coincides with busy dropping.
  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [WIDTH-1:0]      pattern;
  logic [NCH*WIDTH-1:0]  des_data;
  logic [NCH-1:0]        dly_rst, dly_ce, bitslip, ch_ok, ch_fail;
  logic                  dly_inc, busy, done;
  logic [NCH*TW-1:0]     tap_out;
  logic [NCH*(TW+1)-1:0] eye_len;
  logic [3:0]            state_dbg;

  int checks = 0;
  int errors = 0;

  // Per-lane scenarios: stable-tap mask, initial rotation, and the hand-derived results.
  logic [TAPS-1:0] win [NCH] = '{32'h001FFC00, 32'hFFFFFFFF, 32'h03F000FC, 32'hF0000000,
                                 32'h000000E0, 32'h001FFC00, 32'h001FFFCF, 32'hFFFEFFFF};
  int rot    [NCH] = '{2, 0, 0, 1, 0, 7, 3, 5};
  int e_ok   [NCH] = '{1, 1, 1, 1, 0, 0, 1, 1};
  int e_fail [NCH] = '{0, 0, 0, 0, 1, 1, 0, 0};
  int e_tap  [NCH] = '{15, 15, 4, 29, 0, 15, 13, 7};
  int e_eye  [NCH] = '{11, 32, 6, 4, 3, 11, 15, 16};
  int e_slip [NCH] = '{2, 0, 0, 1, 0, 6, 3, 5};
  int e_rst  [NCH] = '{2, 2, 2, 2, 1, 2, 2, 2};
  int e_ce   [NCH] = '{46, 46, 35, 60, 31, 46, 44, 38};

  int   m_tap [NCH];
  int   m_slip[NCH];
  int   n_rst [NCH];
  int   n_ce  [NCH];
  int   n_slip[NCH];
  int   n_done, multi_err, done_busy_err, first_rst0, first_ce0;
  int   cyc = 0;
  logic tgl = 1'b0;
  logic clr_model;

  adc_lane_align dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .des_data  (des_data),
    .dly_rst   (dly_rst),
    .dly_ce    (dly_ce),
    .dly_inc   (dly_inc),
    .bitslip   (bitslip),
    .busy      (busy),
    .done      (done),
    .ch_ok     (ch_ok),
    .ch_fail   (ch_fail),
    .tap_out   (tap_out),
    .eye_len   (eye_len),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Lane model: stable taps give pattern rotated right by (rot - slips); other taps toggle every cycle.
  for (genvar g = 0; g < NCH; g++) begin : g_lane
    int r;
    logic [2*WIDTH-1:0] dbl;
    assign r   = (rot[g] + 4*WIDTH - m_slip[g]) % WIDTH;
    assign dbl = {pattern, pattern} >> r;
    assign des_data[g*WIDTH +: WIDTH] = dbl[WIDTH-1:0] ^ {WIDTH{tgl & ~win[g][m_tap[g]]}};
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tgl <= ~tgl;
    if (clr_model) begin
      for (int i = 0; i < NCH; i++) begin
        m_tap[i]  <= 0;
        m_slip[i] <= 0;
        n_rst[i]  <= 0;
        n_ce[i]   <= 0;
        n_slip[i] <= 0;
      end
      n_done        <= 0;
      multi_err     <= 0;
      done_busy_err <= 0;
      first_rst0    <= -1;
      first_ce0     <= -1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (dly_rst[i])      m_tap[i] <= 0;
        else if (dly_ce[i])  m_tap[i] <= m_tap[i] + 1;
        if (dly_rst[i]) n_rst[i] <= n_rst[i] + 1;
        if (dly_ce[i])  n_ce[i]  <= n_ce[i] + 1;
        if (bitslip[i]) begin
          m_slip[i] <= m_slip[i] + 1;
          n_slip[i] <= n_slip[i] + 1;
        end
      end
      if ($countones(dly_rst) > 1 || $countones(dly_ce) > 1 || $countones(bitslip) > 1)
        multi_err <= multi_err + 1;
      if (done) begin
        n_done <= n_done + 1;
        if (busy) done_busy_err <= done_busy_err + 1;
      end
      if (dly_rst[0] && first_rst0 < 0) first_rst0 <= cyc;
      if (dly_ce[0] && first_ce0 < 0)   first_ce0  <= cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    clr_model = 1'b1;
    @(negedge clk);
    clr_model = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit poke_fin, output bit got);
    got = 1'b0;
    for (int k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if (poke_fin) start = (state_dbg == 4'd12);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_lanes(input string run);
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("%s ch_ok[%0d]", run, i),   64'(ch_ok[i]),   64'(e_ok[i]));
      check($sformatf("%s ch_fail[%0d]", run, i), 64'(ch_fail[i]), 64'(e_fail[i]));
      check($sformatf("%s tap_out[%0d]", run, i), 64'(tap_out[i*TW +: TW]), 64'(e_tap[i]));
      check($sformatf("%s eye_len[%0d]", run, i), 64'(eye_len[i*(TW+1) +: (TW+1)]), 64'(e_eye[i]));
      check($sformatf("%s bitslips[%0d]", run, i), 64'(n_slip[i]), 64'(e_slip[i]));
      check($sformatf("%s dly_rst_cnt[%0d]", run, i), 64'(n_rst[i]), 64'(e_rst[i]));
      check($sformatf("%s dly_ce_cnt[%0d]", run, i), 64'(n_ce[i]), 64'(e_ce[i]));
    end
  endtask

  initial begin
    bit got;
    int sum;
    rst       = 1'b1;
    start     = 1'b0;
    pattern   = 12'hA5C;
    clr_model = 1'b1;
    repeat (4) @(negedge clk);

    // Reset values
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst dly_inc", 64'(dly_inc), 64'd1);
    check("rst pulses", 64'({dly_rst, dly_ce, bitslip}), 64'd0);
    check("rst ch_ok_fail", 64'({ch_ok, ch_fail}), 64'd0);
    check("rst tap_out", 64'(tap_out), 64'd0);
    check("rst eye_len", 64'(eye_len), 64'd0);
    check("rst state", 64'(state_dbg), 64'd0);
    rst       = 1'b0;
    clr_model = 1'b0;
    @(negedge clk);

    // Run 1: every lane scenario in one pass; a stray start mid-run must be ignored
    check("run1 busy before start", 64'(busy), 64'd0);
    pulse_start();
    check("run1 busy rises", 64'(busy), 64'd1);
    check("run1 state SEL", 64'(state_dbg), 64'd1);
    repeat (300) @(negedge clk);
    pulse_start();
    wait_done(1'b0, got);
    check("run1 done seen", 64'(got), 64'd1);
    check("run1 busy at done", 64'(busy), 64'd0);
    check_lanes("run1");
    @(negedge clk);
    check("run1 done one cycle", 64'(done), 64'd0);
    check("run1 done count", 64'(n_done), 64'd1);
    check("run1 done while busy", 64'(done_busy_err), 64'd0);
    check("run1 multi-lane pulses", 64'(multi_err), 64'd0);
    check("run1 tap sweep period", 64'(first_ce0 - first_rst0), 64'd82);
    check("run1 dly_inc", 64'(dly_inc), 64'd1);

    // Run 2: reset while lane 3 is in CHECK
    clear_model();
    pulse_start();
    got = 1'b0;
    for (int k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if (dly_rst[3]) begin
        got = 1'b1;
        break;
      end
    end
    check("run2 lane3 reached", 64'(got), 64'd1);
    repeat (30) @(negedge clk);
    check("run2 in CHECK", 64'(state_dbg), 64'd3);
    check("run2 lanes0-2 ok", 64'(ch_ok), 64'h07);
    check("run2 busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("run2 rst busy", 64'(busy), 64'd0);
    check("run2 rst pulses", 64'({dly_rst, dly_ce, bitslip, done}), 64'd0);
    check("run2 rst ch_ok", 64'(ch_ok), 64'd0);
    check("run2 rst tap_out", 64'(tap_out), 64'd0);
    check("run2 rst state", 64'(state_dbg), 64'd0);
    check("run2 rst dly_inc", 64'(dly_inc), 64'd1);
    rst = 1'b0;
    clear_model();
    repeat (100) @(negedge clk);
    sum = 0;
    for (int i = 0; i < NCH; i++) sum += n_rst[i] + n_ce[i] + n_slip[i];
    check("run2 no pulses after rst", 64'(sum), 64'd0);
    check("run2 idle busy", 64'(busy), 64'd0);

    // Run 3: retrain from lane 0; a start coinciding with FIN must be ignored
    clear_model();
    pulse_start();
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (dly_rst != '0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("run3 first dly_rst seen", 64'(got), 64'd1);
    check("run3 first dly_rst lane0", 64'(dly_rst), 64'h01);
    wait_done(1'b1, got);
    check("run3 done seen", 64'(got), 64'd1);
    check_lanes("run3");
    repeat (10) @(negedge clk);
    check("run3 FIN start ignored busy", 64'(busy), 64'd0);
    check("run3 FIN start ignored state", 64'(state_dbg), 64'd0);
    check("run3 done count", 64'(n_done), 64'd1);
    check("run3 multi-lane pulses", 64'(multi_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
